// File: rtl/dsce_pkg.sv
// dsce_pkg: shared widths, padding pattern and block FIFO entry type for the cipher datapath
package dsce_pkg;
    localparam int WORD_W = 64;
    localparam int BLK_W  = 128;
    localparam int SEQ_W  = 16;
    localparam logic [WORD_W-1:0] PAD_WORD = 64'h0000_0000_0000_0001;

    typedef struct packed {
        logic [BLK_W-1:0] data;
        logic             last;
        logic             padded;
        logic [SEQ_W-1:0] seq;
    } blk_entry_t;

    typedef enum logic {EMPTY_LO, HAVE_LO} pack_state_t;
endpackage

// File: rtl/block_fifo.sv
// block_fifo: first-word-fall-through FIFO; the head holds its last popped value while empty
module block_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] hold_q;
    logic             wr_en, rd_en;
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (rd_en) hold_q <= mem_q[rd_ptr_q];
            count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rd_data = empty ? hold_q : mem_q[rd_ptr_q];
endmodule

// File: rtl/block_pack.sv
// block_pack: pairs 64-bit packed words into tagged 128-bit blocks, padding odd-length messages
module block_pack
    import dsce_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    input  logic              word_last,
    output logic              stall_out,
    output logic [BLK_W-1:0]  blk_out,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic              blk_last,
    output logic              blk_padded,
    output logic [SEQ_W-1:0]  blk_seq
);
    pack_state_t       state_q, state_d;
    logic [WORD_W-1:0] lo_q, lo_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    blk_entry_t        entry, head;
    logic              acc, push, fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] unused_count;
    assign acc = word_valid & ~stall_out;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY_LO;
            lo_q    <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            seq_q   <= seq_d;
        end
    end
    always_comb begin
        state_d = acc ? ((state_q == EMPTY_LO && !word_last) ? HAVE_LO : EMPTY_LO) : state_q;
    end
    // A lone final word is completed with the pad pattern in the upper half.
    always_comb begin
        push         = acc & (state_q == HAVE_LO | word_last);
        entry.data   = (state_q == HAVE_LO) ? {word_in, lo_q} : {PAD_WORD, word_in};
        entry.last   = word_last;
        entry.padded = state_q == EMPTY_LO;
        entry.seq    = seq_q;
        lo_d         = (acc && state_q == EMPTY_LO) ? word_in : lo_q;
        seq_d        = push ? (word_last ? '0 : seq_q + SEQ_W'(1)) : seq_q;
    end
    block_fifo #(.DEPTH(DEPTH), .WIDTH($bits(blk_entry_t))) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (blk_ready),
        .wr_data (entry),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_count)
    );
    assign stall_out  = fifo_full;
    assign blk_valid  = ~fifo_empty;
    assign blk_out    = head.data;
    assign blk_last   = head.last;
    assign blk_padded = head.padded;
    assign blk_seq    = head.seq;
endmodule

// File: tb/tb_block_pack.sv
// tb_block_pack: table vectors, directed corner sequences and a random run against a message-level model
module tb_block_pack;
    localparam int DEPTH = 4;
    logic         clk = 0, rst = 1;
    logic [63:0]  word_in = '0;
    logic         word_valid = 0, word_last = 0, blk_ready = 0;
    logic         stall_out, blk_valid, blk_last, blk_padded;
    logic [127:0] blk_out;
    logic [15:0]  blk_seq;

    block_pack #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
        .stall_out(stall_out), .blk_out(blk_out), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_last(blk_last), .blk_padded(blk_padded), .blk_seq(blk_seq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic         pad;
        logic [15:0]  seq;
    } blk_t;

    typedef struct {
        logic [63:0]  w0, w1;
        int           n;
        logic [127:0] exp_data;
        logic         exp_pad;
    } vec_t;

    int cmp_n = 0, err_n = 0;
    blk_t        q[$];
    logic [63:0] pend[$];
    int          blk_idx = 0;

    task automatic chk(input string nm, input logic [145:0] act, input logic [145:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Message-level reference: words accumulate; every pair, or a final odd word, forms one block.
    task automatic model_accept(input logic [63:0] w, input logic l);
        blk_t b;
        pend.push_back(w);
        if (l || pend.size() == 2) begin
            b.data = (pend.size() == 2) ? {w, pend[0]} : {64'h1, w};
            b.pad  = pend.size() == 1;
            b.last = l;
            b.seq  = 16'(blk_idx);
            blk_idx = l ? 0 : blk_idx + 1;
            pend.delete();
            q.push_back(b);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pend.delete();
        blk_idx = 0;
    endtask

    task automatic check_model();
        chk("stall", stall_out, q.size() == DEPTH);
        chk("valid", blk_valid, q.size() != 0);
        if (q.size() != 0) chk("head", {blk_out, blk_last, blk_padded, blk_seq}, q[0]);
    endtask

    task automatic cycle(input logic v, input logic l, input logic [63:0] w, input logic r);
        logic a, p;
        word_valid = v; word_last = l; word_in = w; blk_ready = r;
        check_model();
        a = v && q.size() != DEPTH;
        p = r && q.size() != 0;
        @(posedge clk);
        if (p) void'(q.pop_front());
        if (a) model_accept(w, l);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_blk_out", blk_out, 0);
        chk("rst_valid", blk_valid, 0);
        chk("rst_last", blk_last, 0);
        chk("rst_padded", blk_padded, 0);
        chk("rst_seq", blk_seq, 0);
        chk("rst_stall", stall_out, 0);
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 50) begin
            cycle(0, 0, 64'h0, 1);
            g++;
        end
        chk("drain_empty", blk_valid, 0);
    endtask

    vec_t        tbl[4];
    logic [63:0] wv[10];
    logic [15:0] seq5[5];
    logic        rv, rl, rr;
    logic [63:0] rw;

    initial begin
        tbl[0] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 2,
                   {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0};
        tbl[1] = '{64'hABCD_ABCD_ABCD_ABCD, 64'h0, 1,
                   {64'h0000_0000_0000_0001, 64'hABCD_ABCD_ABCD_ABCD}, 1'b1};
        tbl[2] = '{64'h0, 64'h0, 1, {64'h0000_0000_0000_0001, 64'h0}, 1'b1};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2,
                   {64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0};
        for (int i = 0; i < 10; i++) wv[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
        seq5 = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2};

        #3 rst = 0;
        repeat (2) @(posedge clk);
        #1 check_reset();
        @(negedge clk) rst = 1;
        @(posedge clk) #1;
        check_reset();

        foreach (tbl[i]) begin
            cycle(1, tbl[i].n == 1, tbl[i].w0, 1);
            if (tbl[i].n == 2) begin
                chk("tbl_latency", blk_valid, 0);
                cycle(1, 1, tbl[i].w1, 1);
            end
            chk("tbl_valid", blk_valid, 1);
            chk("tbl_data", blk_out, tbl[i].exp_data);
            chk("tbl_flags", {blk_last, blk_padded, blk_seq}, {1'b1, tbl[i].exp_pad, 16'd0});
            cycle(0, 0, 64'h0, 1);
        end

        // Five-word message: blocks after words 2, 4 and 5; then a new message restarts at seq 0.
        for (int i = 0; i < 5; i++) begin
            cycle(1, i == 4, wv[i], 1);
            if (i == 1 || i == 3 || i == 4) begin
                chk("msg5_seq", blk_seq, seq5[i]);
                chk("msg5_flags", {blk_last, blk_padded}, {i == 4, i == 4});
            end
        end
        cycle(1, 0, wv[5], 1);
        cycle(1, 1, wv[6], 1);
        chk("msg_next_seq", {blk_valid, blk_seq}, {1'b1, 16'd0});
        drain();

        // Back-pressure: ten words with the consumer stalled.
        begin
            int idx = 0, g = 0;
            logic a;
            while (idx < 8 && g < 50) begin
                a = q.size() != DEPTH;
                cycle(1, 0, wv[idx], 0);
                if (a) idx++;
                g++;
            end
            chk("full_stall", stall_out, 1);
            cycle(1, 0, wv[8], 1);
            chk("pop_unstall", {stall_out, blk_valid}, 2'b01);
            cycle(1, 0, wv[8], 0);
            cycle(1, 1, wv[9], 0);
            chk("refill_stall", stall_out, 1);
            drain();
        end

        // Reset while holding a low word with two blocks queued.
        for (int i = 0; i < 5; i++) cycle(1, 0, wv[i], 0);
        word_valid = 0; word_last = 0;
        rst = 0;
        #1 check_reset();
        model_clear();
        @(negedge clk) rst = 1;
        @(posedge clk) #1;
        cycle(1, 0, 64'hDEAD_BEEF_0000_0001, 1);
        cycle(1, 1, 64'hCAFE_F00D_0000_0002, 1);
        chk("post_rst_blk", {blk_out, blk_padded, blk_seq},
            {64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001, 1'b0, 16'd0});
        cycle(0, 0, 64'h0, 1);

        rv = 0; rl = 0; rw = '0;
        for (int c = 0; c < 400; c++) begin
            if (q.size() != DEPTH || !rv) begin
                rv = $urandom_range(0, 3) != 0;
                rl = $urandom_range(0, 3) == 0;
                rw = {$urandom, $urandom};
            end
            rr = $urandom_range(0, 2) != 0;
            cycle(rv, rl, rw, rr);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
